// File: rtl/adc_serial_capture.sv
// Periodic four-channel serial ADC capture: convst pulse, shared sclk/csn readout, one-cycle strobe.
// State | meaning: IDLE wait for tick | CONVERT convst high | SHIFT clock 16 bits | DONE publish sample
module adc_serial_capture #(
  parameter int CLK_DIV       = 2,
  parameter int CONV_CYCLES   = 40,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        ADC_I_clk,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic        I_clrOverrun,
  input  logic        ADC_I_sdoA,
  input  logic        ADC_I_sdoB,
  input  logic        ADC_I_sdoC,
  input  logic        ADC_I_sdoD,
  output logic        ADC_O_convst,
  output logic        ADC_O_csn,
  output logic        ADC_O_sclk,
  output logic [15:0] O_chanA,
  output logic [15:0] O_chanB,
  output logic [15:0] O_chanC,
  output logic [15:0] O_chanD,
  output logic        O_chanAvalid,
  output logic        O_chanBvalid,
  output logic        O_chanCvalid,
  output logic        O_chanDvalid,
  output logic        O_busy,
  output logic        O_overrun,
  output logic [15:0] O_sampleCount
);

  localparam int CNT_MAX = (CONV_CYCLES > CLK_DIV) ? CONV_CYCLES : CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX) + 1;
  localparam int PW      = $clog2(SAMPLE_PERIOD);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_phase, w_phase_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic [PW-1:0] r_period;
  logic [15:0]   r_sr   [4];
  logic [15:0]   r_chan [4];
  logic          r_convst, r_csn, r_sclk, r_valid, r_busy, r_overrun;
  logic [15:0]   r_sample_cnt;
  logic          w_tick, w_sample;
  logic [3:0]    w_sdo;

  assign w_sdo  = {ADC_I_sdoD, ADC_I_sdoC, ADC_I_sdoB, ADC_I_sdoA};
  assign w_tick = I_en && (r_period == PW'(SAMPLE_PERIOD - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick) begin
          w_state_nxt = CONVERT;
          w_cnt_nxt   = CW'(CONV_CYCLES - 1);
        end
      end
      CONVERT: begin
        if (r_cnt == '0) begin
          w_state_nxt = SHIFT;
          w_cnt_nxt   = CW'(CLK_DIV - 1);
          w_phase_nxt = 1'b0;
          w_bit_nxt   = 4'd15;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      SHIFT: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (!r_phase) begin
          w_phase_nxt = 1'b1;
          w_cnt_nxt   = CW'(CLK_DIV - 1);
        end else begin
          // last cycle of the high phase: capture this bit
          w_sample = 1'b1;
          if (r_bit == 4'd0) begin
            w_state_nxt = DONE;
          end else begin
            w_bit_nxt   = r_bit - 4'd1;
            w_phase_nxt = 1'b0;
            w_cnt_nxt   = CW'(CLK_DIV - 1);
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ADC_I_clk) begin
    if (I_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_phase      <= 1'b0;
      r_bit        <= 4'd0;
      r_period     <= '0;
      r_convst     <= 1'b0;
      r_csn        <= 1'b1;
      r_sclk       <= 1'b0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_sample_cnt <= 16'd0;
      for (int i = 0; i < 4; i++) begin
        r_sr[i]   <= 16'd0;
        r_chan[i] <= 16'd0;
      end
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;

      if (!I_en || w_tick) r_period <= '0;
      else                 r_period <= r_period + 1'b1;

      // outputs registered from the next state so they line up with r_state
      r_convst <= (w_state_nxt == CONVERT);
      r_csn    <= (w_state_nxt != SHIFT);
      r_sclk   <= (w_state_nxt == SHIFT) && w_phase_nxt;
      r_valid  <= (w_state_nxt == DONE);
      r_busy   <= (w_state_nxt != IDLE);

      if (w_sample) begin
        for (int i = 0; i < 4; i++) r_sr[i] <= {r_sr[i][14:0], w_sdo[i]};
      end
      if (w_state_nxt == DONE) begin
        for (int i = 0; i < 4; i++) r_chan[i] <= {r_sr[i][14:0], w_sdo[i]};
        r_sample_cnt <= r_sample_cnt + 16'd1;
      end

      if (w_tick && (r_state != IDLE)) r_overrun <= 1'b1;
      else if (I_clrOverrun)           r_overrun <= 1'b0;
    end
  end

  assign ADC_O_convst  = r_convst;
  assign ADC_O_csn     = r_csn;
  assign ADC_O_sclk    = r_sclk;
  assign O_chanA       = r_chan[0];
  assign O_chanB       = r_chan[1];
  assign O_chanC       = r_chan[2];
  assign O_chanD       = r_chan[3];
  assign O_chanAvalid  = r_valid;
  assign O_chanBvalid  = r_valid;
  assign O_chanCvalid  = r_valid;
  assign O_chanDvalid  = r_valid;
  assign O_busy        = r_busy;
  assign O_overrun     = r_overrun;
  assign O_sampleCount = r_sample_cnt;

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed/random bench for adc_serial_capture: default instance plus a fast-period instance for overrun.
module tb_adc_serial_capture;
  localparam int DIV  = 2;
  localparam int CONV = 40;
  localparam int PER  = 200;
  localparam int LAT  = CONV + 32 * DIV;
  localparam int DIV2 = 1;
  localparam int PER2 = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  logic rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic sdoA, sdoB, sdoC, sdoD;
  logic convst, csn, sclk, vA, vB, vC, vD, busy, ovr;
  logic [15:0] chA, chB, chC, chD, cnt;

  adc_serial_capture #(.CLK_DIV(DIV), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PER)) dut1 (
    .ADC_I_clk(clk), .I_rst(rst), .I_en(en), .I_clrOverrun(clr),
    .ADC_I_sdoA(sdoA), .ADC_I_sdoB(sdoB), .ADC_I_sdoC(sdoC), .ADC_I_sdoD(sdoD),
    .ADC_O_convst(convst), .ADC_O_csn(csn), .ADC_O_sclk(sclk),
    .O_chanA(chA), .O_chanB(chB), .O_chanC(chC), .O_chanD(chD),
    .O_chanAvalid(vA), .O_chanBvalid(vB), .O_chanCvalid(vC), .O_chanDvalid(vD),
    .O_busy(busy), .O_overrun(ovr), .O_sampleCount(cnt));

  logic rst2 = 1'b1, en2 = 1'b0, clr2 = 1'b0;
  logic convst2, csn2, sclk2, vA2, vB2, vC2, vD2, busy2, ovr2;
  logic [15:0] chA2, chB2, chC2, chD2, cnt2;

  adc_serial_capture #(.CLK_DIV(DIV2), .CONV_CYCLES(CONV), .SAMPLE_PERIOD(PER2)) dut2 (
    .ADC_I_clk(clk), .I_rst(rst2), .I_en(en2), .I_clrOverrun(clr2),
    .ADC_I_sdoA(1'b1), .ADC_I_sdoB(1'b0), .ADC_I_sdoC(1'b1), .ADC_I_sdoD(1'b0),
    .ADC_O_convst(convst2), .ADC_O_csn(csn2), .ADC_O_sclk(sclk2),
    .O_chanA(chA2), .O_chanB(chB2), .O_chanC(chC2), .O_chanD(chD2),
    .O_chanAvalid(vA2), .O_chanBvalid(vB2), .O_chanCvalid(vC2), .O_chanDvalid(vD2),
    .O_busy(busy2), .O_overrun(ovr2), .O_sampleCount(cnt2));

  // ADC model: MSB presented when csn falls, next bit after each sclk fall
  logic [15:0] adc_w [4];
  int idx = 15;
  always @(negedge csn) idx = 15;
  always @(negedge sclk) if (idx > 0) idx = idx - 1;
  assign sdoA = adc_w[0][idx];
  assign sdoB = adc_w[1][idx];
  assign sdoC = adc_w[2][idx];
  assign sdoD = adc_w[3][idx];

  logic [15:0] model_cnt = 16'd0;
  int last_start = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 4; i++) adc_w[i] = 16'($urandom);
  endtask

  task automatic observe_sample(input int exp_start, input bit drop_en);
    int t0, t_strobe, n_conv, n_csn, n_rise, bad_per, last_rise;
    logic prev;
    t0 = -1;
    for (int i = 0; i < 1000 && t0 < 0; i++) begin
      if (convst) t0 = cyc;
      else step();
    end
    chk("conv_start", t0, exp_start);
    last_start = t0;
    if (drop_en) en = 1'b0;
    chk("busy_convert", busy, 1'b1);
    t_strobe = -1; n_conv = 0; n_csn = 0; n_rise = 0; bad_per = 0; last_rise = -1; prev = 1'b0;
    for (int i = 0; i < 400 && t_strobe < 0; i++) begin
      if (convst) n_conv++;
      if (!csn) n_csn++;
      if (sclk && !prev) begin
        if (last_rise >= 0 && (cyc - last_rise) != 2 * DIV) bad_per++;
        last_rise = cyc;
        n_rise++;
      end
      prev = sclk;
      if (vA | vB | vC | vD) t_strobe = cyc;
      else step();
    end
    model_cnt = model_cnt + 16'd1;
    chk("convst_len", n_conv, CONV);
    chk("csn_low_len", n_csn, 32 * DIV);
    chk("sclk_pulses", n_rise, 16);
    chk("sclk_period_bad", bad_per, 0);
    chk("strobe_latency", t_strobe - t0, LAT);
    chk("valid_all", {vA, vB, vC, vD}, 4'hF);
    chk("done_csn_sclk_convst", {csn, sclk, convst}, 3'b100);
    chk("chanAB", {chA, chB}, {adc_w[0], adc_w[1]});
    chk("chanCD", {chC, chD}, {adc_w[2], adc_w[3]});
    chk("sample_count", cnt, model_cnt);
    step();
    chk("valid_one_cycle", {vA, vB, vC, vD}, 4'h0);
    chk("busy_idle_after", busy, 1'b0);
    chk("chan_hold", {chA, chD}, {adc_w[0], adc_w[3]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, t, n;
    logic prev;
    int q[$];

    adc_w[0] = 16'h8001; adc_w[1] = 16'h7FFE; adc_w[2] = 16'hFFFF; adc_w[3] = 16'h0000;
    repeat (3) step();
    chk("rst_ctrl", {convst, csn, sclk, busy, ovr}, 5'b01000);
    chk("rst_chanAB", {chA, chB}, 32'd0);
    chk("rst_chanCD", {chC, chD}, 32'd0);
    chk("rst_valid", {vA, vB, vC, vD}, 4'h0);
    chk("rst_count", cnt, 16'd0);

    // first sample with fixed words, then nine random periodic samples
    rst = 1'b0; en = 1'b1; k = cyc;
    observe_sample(k + PER, 1'b0);
    for (int s = 2; s <= 10; s++) begin
      randomize_words();
      observe_sample(last_start + PER, 1'b0);
    end
    chk("count_after_10", cnt, 16'd10);
    chk("no_overrun_periodic", ovr, 1'b0);

    // disable during CONVERT: sample completes, then silence
    randomize_words();
    observe_sample(last_start + PER, 1'b1);
    n = 0;
    repeat (400) begin
      step();
      if (convst) n++;
    end
    chk("no_convst_disabled", n, 0);
    en = 1'b1; k = cyc;
    randomize_words();
    observe_sample(k + PER, 1'b0);

    // reset in the middle of SHIFT
    randomize_words();
    t = -1;
    for (int i = 0; i < 400 && t < 0; i++) begin
      if (convst) t = cyc;
      else step();
    end
    chk("rstcase_start", t, last_start + PER);
    n = 0; prev = 1'b0;
    for (int i = 0; i < 300 && n < 8; i++) begin
      step();
      if (sclk && !prev) n++;
      prev = sclk;
    end
    chk("rstcase_in_shift", {csn, n[4:0]}, {1'b0, 5'd8});
    rst = 1'b1;
    step();
    rst = 1'b0; k = cyc;
    model_cnt = 16'd0;
    chk("midrst_ctrl", {convst, csn, sclk, busy, ovr}, 5'b01000);
    chk("midrst_valid", {vA, vB, vC, vD}, 4'h0);
    chk("midrst_chan", {chA, chD}, 32'd0);
    chk("midrst_count", cnt, 16'd0);
    n = 0;
    repeat (150) begin
      if (vA | vB | vC | vD) n++;
      step();
    end
    chk("midrst_no_strobe", n, 0);
    observe_sample(k + PER, 1'b0);

    // sample counter wrap
    force dut1.r_sample_cnt = 16'hFFFE;
    #1;
    release dut1.r_sample_cnt;
    model_cnt = 16'hFFFE;
    randomize_words();
    observe_sample(last_start + PER, 1'b0);
    randomize_words();
    observe_sample(last_start + PER, 1'b0);
    chk("count_wrapped", cnt, 16'h0000);

    // fast period: ticks every 50 cycles, sample takes 74 -> every other tick dropped
    step();
    rst2 = 1'b0; en2 = 1'b1; k = cyc;
    for (int off = 0; off <= 330; off++) begin
      clr2 = (off == 120 || off == 199);
      if (off == 99)  chk("ovr_before_drop", ovr2, 1'b0);
      if (off == 100) chk("ovr_after_drop", ovr2, 1'b1);
      if (off == 121) chk("ovr_cleared", ovr2, 1'b0);
      if (off == 200) chk("ovr_set_wins", ovr2, 1'b1);
      if (vA2 | vB2 | vC2 | vD2) begin
        q.push_back(off);
        chk("p50_valid_all", {vA2, vB2, vC2, vD2}, 4'hF);
      end
      step();
    end
    clr2 = 1'b0;
    chk("p50_strobes", q.size(), 3);
    if (q.size() == 3) begin
      chk("p50_first_strobe", q[0], (PER2 - 1) + 1 + CONV + 32 * DIV2);
      chk("p50_gap1", q[1] - q[0], 2 * PER2);
      chk("p50_gap2", q[2] - q[1], 2 * PER2);
    end
    chk("p50_chan", {chA2, chB2}, 32'hFFFF_0000);
    chk("p50_chanCD", {chC2, chD2}, 32'hFFFF_0000);
    chk("p50_count", cnt2, 16'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
